psram_port_arbiter: RTL
=======================

Name: psram_port_arbiter

Overview:
- Two-port arbiter sharing one qqspi PSRAM/flash controller between two native valid/ready memory requesters.
- Typical pairing: port 0 is the instruction fetch, port 1 is the data load/store.
- Sits between the CPU bus split and the qqspi instance.
- Sequences exactly one transaction at a time and enforces the controller's ready-drop recovery before issuing the next request.

Parameters:
ADDR_W, 23, word-address width shared by both ports and the controller
FIXED_PRIO, 0, 0 = round-robin on tie; 1 = port 0 always wins a tie

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
m0_valid  input  1  port 0 request
m0_ready  output  1  port 0 completion pulse
m0_addr  input  ADDR_W  port 0 word address
m0_wdata  input  32  port 0 write data
m0_wstrb  input  4  port 0 byte strobes; 0 = read
m0_rdata  output  32  port 0 read data
m1_valid  input  1  port 1 request
m1_ready  output  1  port 1 completion pulse
m1_addr  input  ADDR_W  port 1 word address
m1_wdata  input  32  port 1 write data
m1_wstrb  input  4  port 1 byte strobes
m1_rdata  output  32  port 1 read data
mem_valid  output  1  request to controller
mem_ready  input  1  controller completion (registered, held until valid drops)
mem_addr  output  ADDR_W  latched address to controller
mem_wdata  output  32  latched write data
mem_wstrb  output  4  latched strobes
mem_rdata  input  32  controller read data
grant  output  2  one-hot owner of the current transaction; 0 when idle

Behaviour:
- All state on posedge clk; async clear on resetn low.
- Reset values: mem_valid=0, mem_addr/wdata/wstrb=0, m0/m1_ready=0, m0/m1_rdata=0, grant=0, last_grant=port 1 (so port 0 wins the first tie), state=IDLE.
- FSM states: IDLE, ISSUE, COMPLETE, RECOVER.
- IDLE:
  - Stays in IDLE while mem_ready=1.
  - Otherwise, if any mX_valid: select winner. Single valid wins. On a tie, FIXED_PRIO=1 selects port 0; otherwise the port != last_grant wins.
  - Latch the winner's addr/wdata/wstrb into the mem_* registers, set grant, set mem_valid=1, go to ISSUE.
  - Request seen at cycle N gives mem_valid=1 at cycle N+1.
- ISSUE:
  - mem_valid and the mem_* fields are held stable.
  - On mem_ready=1: capture mem_rdata into the granted port's rdata register, pulse that port's ready for exactly 1 cycle (next cycle), drop mem_valid, set last_grant, go to COMPLETE.
  - No timeout; waits indefinitely.
- COMPLETE: one cycle. mX_ready=1 for the granted port; grant still valid. Go to RECOVER.
- RECOVER: mX_ready=0, grant=0. Wait until mem_ready=0, then go to IDLE.
- Latency: mem_ready at cycle K gives mX_ready at K+1. Earliest next mem_valid is K+4 (COMPLETE, RECOVER, IDLE).
- Requester rule: a port must deassert valid (or present a new request) in the cycle after its mX_ready pulse. Valid sampled in IDLE is always treated as a new request.
- Write is any nonzero wstrb; the arbiter passes strobes unmodified and does not inspect read/write.
- mX_rdata holds its value until that port's next completion. For writes it captures mem_rdata as is (don't-care to requesters).
- Requester inputs are sampled only in IDLE. Changes to a losing port's fields while the other port is in service are ignored until the next arbitration.
- A port deasserting valid before grant is a legal withdrawal and is not serviced.
- Starvation: round-robin guarantees each continuously valid port service within 2 transactions.
- Reset mid-transaction: all outputs clear immediately, and mem_valid drops asynchronously. The controller must be reset in the same reset domain; no partial completion is reported.

Test Plan:
- Reset, then m0 read addr 0x000010 with controller model returning 0x12345678 after 20 cycles -> mem_valid at +1, m0_ready 1-cycle pulse 1 cycle after mem_ready, m0_rdata=0x12345678, grant=01 during service, m1_ready never asserted.
- m1 write addr 0x1FFFFF, wdata 0xA5A5A5A5, wstrb 0010 -> mem_addr/wdata/wstrb match exactly and stay stable throughout ISSUE, m1_ready single pulse.
- Both valid continuously, FIXED_PRIO=0 -> grants alternate 01,10,01,10 over 4 transactions; first grant is port 0 after reset.
- Same stimulus with FIXED_PRIO=1 -> port 0 is served every time while it stays valid; port 1 is served only once m0_valid drops.
- Controller holds mem_ready high 3 extra cycles after mem_valid falls -> arbiter stays in RECOVER, no new mem_valid until 1 cycle after mem_ready=0.
- Assert resetn=0 mid-ISSUE -> mem_valid, grant and both ready outputs go to 0 without waiting for a clk edge; after release, a new m0 request is served normally.

Source files
------------

// File: rtl/psram_port_arbiter.sv
// psram_port_arbiter
// Shares one qqspi PSRAM/flash controller between two valid/ready requesters
// (typically instruction fetch on port 0, load/store on port 1). Exactly one
// transaction is in flight at a time, and the controller must drop mem_ready
// before the next request is issued.
module psram_port_arbiter #(
  parameter int ADDR_W     = 23,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic [31:0]       m1_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COMPLETE = 2'd2,
    ST_RECOVER  = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                last_grant_r, last_grant_nxt_s;  // 0: port 0, 1: port 1
  logic                mem_valid_r, mem_valid_nxt_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_nxt_s;
  logic [31:0]         mem_wdata_r, mem_wdata_nxt_s;
  logic [3:0]          mem_wstrb_r, mem_wstrb_nxt_s;
  logic [1:0]          grant_r, grant_nxt_s;
  logic                m0_ready_r, m0_ready_nxt_s;
  logic                m1_ready_r, m1_ready_nxt_s;
  logic [31:0]         m0_rdata_r, m0_rdata_nxt_s;
  logic [31:0]         m1_rdata_r, m1_rdata_nxt_s;
  logic                pick_m1_s;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    mem_valid_nxt_s  = mem_valid_r;
    mem_addr_nxt_s   = mem_addr_r;
    mem_wdata_nxt_s  = mem_wdata_r;
    mem_wstrb_nxt_s  = mem_wstrb_r;
    grant_nxt_s      = grant_r;
    m0_ready_nxt_s   = 1'b0;
    m1_ready_nxt_s   = 1'b0;
    m0_rdata_nxt_s   = m0_rdata_r;
    m1_rdata_nxt_s   = m1_rdata_r;
    pick_m1_s        = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // A still-high mem_ready means the controller has not recovered yet.
        if (!mem_ready && (m0_valid || m1_valid)) begin
          if (m0_valid && m1_valid) begin
            // Tie: port 0 in fixed mode, otherwise the port not served last.
            pick_m1_s = FIXED_PRIO ? 1'b0 : ~last_grant_r;
          end else begin
            pick_m1_s = m1_valid;
          end
          mem_valid_nxt_s = 1'b1;
          mem_addr_nxt_s  = pick_m1_s ? m1_addr  : m0_addr;
          mem_wdata_nxt_s = pick_m1_s ? m1_wdata : m0_wdata;
          mem_wstrb_nxt_s = pick_m1_s ? m1_wstrb : m0_wstrb;
          grant_nxt_s     = pick_m1_s ? 2'b10 : 2'b01;
          state_nxt_s     = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          if (grant_r[1]) begin
            m1_rdata_nxt_s = mem_rdata;
            m1_ready_nxt_s = 1'b1;
          end else begin
            m0_rdata_nxt_s = mem_rdata;
            m0_ready_nxt_s = 1'b1;
          end
          mem_valid_nxt_s  = 1'b0;
          last_grant_nxt_s = grant_r[1];
          state_nxt_s      = ST_COMPLETE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_COMPLETE: begin
        grant_nxt_s = 2'b00;
        state_nxt_s = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (!mem_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RECOVER;
        end
      end
      default: begin
        mem_valid_nxt_s = 1'b0;
        grant_nxt_s     = 2'b00;
        state_nxt_s     = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered request, grant and completion outputs; reset clears them at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_r <= 1'b1;
      mem_valid_r  <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= 32'h0000_0000;
      mem_wstrb_r  <= 4'h0;
      grant_r      <= 2'b00;
      m0_ready_r   <= 1'b0;
      m1_ready_r   <= 1'b0;
      m0_rdata_r   <= 32'h0000_0000;
      m1_rdata_r   <= 32'h0000_0000;
    end else begin
      last_grant_r <= last_grant_nxt_s;
      mem_valid_r  <= mem_valid_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
      mem_wdata_r  <= mem_wdata_nxt_s;
      mem_wstrb_r  <= mem_wstrb_nxt_s;
      grant_r      <= grant_nxt_s;
      m0_ready_r   <= m0_ready_nxt_s;
      m1_ready_r   <= m1_ready_nxt_s;
      m0_rdata_r   <= m0_rdata_nxt_s;
      m1_rdata_r   <= m1_rdata_nxt_s;
    end
  end

  assign mem_valid = mem_valid_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wstrb = mem_wstrb_r;
  assign grant     = grant_r;
  assign m0_ready  = m0_ready_r;
  assign m1_ready  = m1_ready_r;
  assign m0_rdata  = m0_rdata_r;
  assign m1_rdata  = m1_rdata_r;

endmodule
